// File: rtl/jtkcpu_irqctl_pkg.sv
// Shared constants for the jtkcpu interrupt controller: register offsets,
// intvec acknowledge bit positions and the NMI state encoding.
package jtkcpu_irqctl_pkg;

    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_FSEL   = 2'd1;
    localparam logic [1:0] REG_PEND   = 2'd2;
    localparam logic [1:0] REG_NMICTL = 2'd3;

    localparam int unsigned INTV_IRQ  = 0;
    localparam int unsigned INTV_FIRQ = 1;
    localparam int unsigned INTV_NMI  = 2;
    localparam int unsigned INTV_RST  = 3;

    typedef enum logic [0:0] {
        StIdle,
        StPulse
    } nmi_state_e;

endpackage

// File: rtl/jtkcpu_irqctl_prio.sv
// Lowest-set-bit finder: returns a one-hot mask selecting the lowest-index
// asserted request, or zero when no request is present.
module jtkcpu_irqctl_prio #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] clr
);

    // Two's complement isolates the lowest set bit.
    always_comb begin
        clr = req & (~req + W'(1));
    end

endmodule

// File: rtl/jtkcpu_irqctl.sv
// Interrupt controller for jtkcpu: edge capture of peripheral requests,
// IRQ/FIRQ routing with auto-acknowledge, and a timed NMI pulse.
module jtkcpu_irqctl
    import jtkcpu_irqctl_pkg::*;
#(
    parameter int unsigned NSRC    = 4,
    parameter int unsigned NMI_LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_src,
    input  logic            cs,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    input  logic [3:0]      intvec,
    output logic            irq_n,
    output logic            firq_n,
    output logic            nmi_n
);

    localparam int unsigned CW = $clog2(NMI_LEN);

    logic [NSRC-1:0] src_q, mask_q, fsel_q, pend_q, pend_d;
    logic [NSRC-1:0] src_rise, irq_req, firq_req, irq_clr, firq_clr, w1c;
    logic            nmi_src_q, nmi_rise, nmi_en_q;
    logic [2:0]      iv_q, iv_rise;
    logic            irq_n_q, firq_n_q;
    logic            wr;
    nmi_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // intvec[3] (reset vector) and upper din bits carry nothing for us.
    logic unused_ok;
    assign unused_ok = ^{intvec[INTV_RST], din};

    assign wr = cs & we & cen;

    jtkcpu_irqctl_prio #(.W(NSRC)) u_prio_irq (
        .req (irq_req),
        .clr (irq_clr)
    );

    jtkcpu_irqctl_prio #(.W(NSRC)) u_prio_firq (
        .req (firq_req),
        .clr (firq_clr)
    );

    always_comb begin
        src_rise = src & ~src_q;
        nmi_rise = nmi_src & ~nmi_src_q;
        iv_rise  = intvec[2:0] & ~iv_q;
        irq_req  = pend_q & mask_q & ~fsel_q;
        firq_req = pend_q & mask_q & fsel_q;
        w1c      = (wr && addr == REG_PEND) ? din[NSRC-1:0] : '0;
        pend_d   = pend_q & ~w1c;
        if (iv_rise[INTV_IRQ])  pend_d = pend_d & ~irq_clr;
        if (iv_rise[INTV_FIRQ]) pend_d = pend_d & ~firq_clr;
        // A fresh edge wins over any clear on the same bit.
        pend_d = pend_d | src_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            nmi_src_q <= 1'b0;
            iv_q      <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            fsel_q    <= '0;
            nmi_en_q  <= 1'b0;
            irq_n_q   <= 1'b1;
            firq_n_q  <= 1'b1;
        end else if (cen) begin
            src_q     <= src;
            nmi_src_q <= nmi_src;
            iv_q      <= intvec[2:0];
            pend_q    <= pend_d;
            irq_n_q   <= ~|irq_req;
            firq_n_q  <= ~|firq_req;
            if (wr) begin
                unique case (addr)
                    REG_MASK:   mask_q   <= din[NSRC-1:0];
                    REG_FSEL:   fsel_q   <= din[NSRC-1:0];
                    REG_NMICTL: nmi_en_q <= din[0];
                    default: ;
                endcase
            end
        end
    end

    // NMI FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NMI FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cen) begin
            unique case (state_q)
                StIdle: begin
                    if (nmi_rise && nmi_en_q) begin
                        state_d = StPulse;
                        cnt_d   = CW'(NMI_LEN - 1);
                    end
                end
                StPulse: begin
                    if (cnt_q == '0 || iv_rise[INTV_NMI]) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // NMI FSM: outputs
    always_comb begin
        nmi_n = (state_q != StPulse);
    end

    assign irq_n  = irq_n_q;
    assign firq_n = firq_n_q;

    always_comb begin
        dout = '0;
        unique case (addr)
            REG_MASK:   dout[NSRC-1:0] = mask_q;
            REG_FSEL:   dout[NSRC-1:0] = fsel_q;
            REG_PEND:   dout[NSRC-1:0] = pend_q;
            REG_NMICTL: dout = {~nmi_n, 6'b0, nmi_en_q};
            default:    dout = '0;
        endcase
    end

endmodule
